nios2_oci_ram_arbiter: RTL

Arbiter and sequencer for the Nios II on-chip-instrumentation (OCI) debug RAM, shared between the JTAG debug path and the CPU debug-monitor slave port. It converts single-cycle JTAG action pulses into auto-incrementing RAM accesses and arbitrates them round-robin against Avalon-style CPU reads and writes. It sits in the system clock domain, downstream of the JTAG sysclk synchronizer and upstream of a single-port synchronous RAM.

---
 rtl/nios2_oci_ram_arbiter.sv | 138 +++++++++++++
 1 files changed

// File: rtl/nios2_oci_ram_arbiter.sv
// ---------------------------------------------------------------------------
// nios2_oci_ram_arbiter : JTAG/CPU round-robin sequencer for the OCI debug RAM
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module nios2_oci_ram_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              jtag_ld_addr_i,
  input  logic [ADDR_W-1:0] jtag_addr_i,
  input  logic              jtag_wr_i,
  input  logic              jtag_rd_i,
  input  logic [DATA_W-1:0] jtag_wdata_i,
  output logic [DATA_W-1:0] jtag_rdata_o,
  output logic              jtag_busy_o,
  output logic              jtag_overrun_o,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic              cpu_read_i,
  input  logic              cpu_write_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  output logic              cpu_waitrequest_o,
  output logic [DATA_W-1:0] cpu_rdata_o,
  output logic              cpu_readdatavalid_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic              ram_we_o,
  output logic [DATA_W-1:0] ram_wdata_o,
  input  logic [DATA_W-1:0] ram_rdata_i
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_CPU  = 2'd1,
    RD_JTAG = 2'd2
  } state_t;

  state_t              state_q;
  logic                cmd_valid_q;
  logic                cmd_wr_q;
  logic [DATA_W-1:0]   cmd_data_q;
  logic [ADDR_W-1:0]   ptr_q;
  logic [ADDR_W-1:0]   ram_addr_q;
  logic                overrun_q;
  logic [DATA_W-1:0]   jtag_rdata_q;
  logic                last_jtag_q;

  logic                cpu_req;
  logic                arb_ok;
  logic                grant_cpu;
  logic                grant_jtag;
  logic                jtag_pulse;
  logic [ADDR_W-1:0]   ptr_d;

  // Grants are masked during reset so nothing reaches the RAM while it is held.
  always_comb begin
    cpu_req    = cpu_read_i | cpu_write_i;
    arb_ok     = (state_q == IDLE) && !reset_i;
    grant_cpu  = arb_ok && cpu_req && (!cmd_valid_q || last_jtag_q);
    grant_jtag = arb_ok && cmd_valid_q && (!cpu_req || !last_jtag_q);
    jtag_pulse = jtag_wr_i | jtag_rd_i;
    ptr_d      = ptr_q + ADDR_W'(1);
  end

  always_comb begin
    ram_we_o            = (grant_cpu && cpu_write_i) || (grant_jtag && cmd_wr_q);
    ram_addr_o          = grant_cpu ? cpu_addr_i : (grant_jtag ? ptr_q : ram_addr_q);
    ram_wdata_o         = grant_jtag ? cmd_data_q : cpu_wdata_i;
    cpu_waitrequest_o   = !grant_cpu;
    cpu_readdatavalid_o = (state_q == RD_CPU) && !reset_i;
    cpu_rdata_o         = ram_rdata_i;
    jtag_busy_o         = cmd_valid_q;
    jtag_overrun_o      = overrun_q;
    jtag_rdata_o        = jtag_rdata_q;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      cmd_valid_q  <= 1'b0;
      cmd_wr_q     <= 1'b0;
      cmd_data_q   <= '0;
      ptr_q        <= '0;
      ram_addr_q   <= '0;
      overrun_q    <= 1'b0;
      jtag_rdata_q <= '0;
      last_jtag_q  <= 1'b1;
    end else begin
      if (grant_cpu || grant_jtag) begin
        ram_addr_q  <= ram_addr_o;
        last_jtag_q <= grant_jtag;
      end

      // Intake only while idle; any pulse arriving while busy is lost and flagged.
      if (!cmd_valid_q) begin
        if (jtag_pulse) begin
          cmd_valid_q <= 1'b1;
          cmd_wr_q    <= jtag_wr_i;
          cmd_data_q  <= jtag_wdata_i;
        end
        if (jtag_ld_addr_i) begin
          ptr_q     <= jtag_addr_i;
          overrun_q <= 1'b0;
        end
      end else if (jtag_pulse || jtag_ld_addr_i) begin
        overrun_q <= 1'b1;
      end

      case (state_q)
        IDLE: begin
          if (grant_cpu && !cpu_write_i) begin
            state_q <= RD_CPU;
          end else if (grant_jtag) begin
            if (cmd_wr_q) begin
              cmd_valid_q <= 1'b0;
              ptr_q       <= ptr_d;
            end else begin
              state_q <= RD_JTAG;
            end
          end
        end
        RD_CPU: state_q <= IDLE;
        RD_JTAG: begin
          jtag_rdata_q <= ram_rdata_i;
          ptr_q        <= ptr_d;
          cmd_valid_q  <= 1'b0;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
